// File: rtl/video_ram_fill.sv
// ============================================================================
// Module   : video_ram_fill
// Brief    : Shared video RAM: CPU word port, pixel read port and a fill engine.
//            Optional per-byte fill mask when VIDEO_RAM_FILL_MASK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_ram_fill #(
    parameter int ADDR_WIDTH   = 12,
    parameter int PXL_WIDTH    = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic [31:0]                                cpu_addr_i,
    input  logic [31:0]                                cpu_write_data_i,
    input  logic [3:0]                                 cpu_write_mask_i,
    output logic [31:0]                                cpu_read_data_o,
    input  logic [ADDR_WIDTH-$clog2(PXL_WIDTH/8)-1:0]  pxl_addr_i,
    output logic [PXL_WIDTH-1:0]                       pxl_data_o,
    input  logic                                       fill_start_i,
    input  logic [ADDR_WIDTH-3:0]                      fill_base_i,
    input  logic [ADDR_WIDTH-2:0]                      fill_count_i,
    input  logic [31:0]                                fill_value_i,
`ifdef VIDEO_RAM_FILL_MASK_EN
    input  logic [3:0]                                 fill_mask_i,
`endif
    output logic                                       fill_busy_o,
    output logic                                       fill_done_o
);

    localparam int c_DEPTH     = 2 ** (ADDR_WIDTH - 2);
    localparam int c_WA        = ADDR_WIDTH - 2;
    localparam int c_RW        = ADDR_WIDTH - 1;
    localparam int c_PA        = ADDR_WIDTH - $clog2(PXL_WIDTH / 8);
    localparam int c_LANE_BITS = $clog2(32 / PXL_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [31:0]          r_mem [c_DEPTH];

    state_t               r_state, w_state_nxt;
    logic [c_WA-1:0]      r_ptr, w_ptr_nxt;
    logic [c_RW-1:0]      r_rem, w_rem_nxt;
    logic [31:0]          r_fill_value, w_fill_value_nxt;
    logic [3:0]           r_fill_mask, w_fill_mask_nxt;
    logic [3:0]           w_fill_mask_in;
    logic                 w_fill_we;
    logic                 r_busy, r_done;

    logic [c_WA-1:0]      w_cpu_word;
    logic                 w_cpu_we;
    logic                 w_unused_addr;
    logic [c_WA-1:0]      w_pxl_word;
    logic [1:0]           w_pxl_lane;
    logic [31:0]          w_pxl_word_data;
    logic [PXL_WIDTH-1:0] w_pxl_sel;
    logic [31:0]          r_cpu_q1;
    logic [PXL_WIDTH-1:0] r_pxl_q1;

    assign w_cpu_word    = cpu_addr_i[ADDR_WIDTH-1:2];
    assign w_cpu_we      = (cpu_write_mask_i != 4'h0);
    assign w_unused_addr = &{cpu_addr_i[31:ADDR_WIDTH], cpu_addr_i[1:0]};

`ifdef VIDEO_RAM_FILL_MASK_EN
    assign w_fill_mask_in = fill_mask_i;
`else
    assign w_fill_mask_in = 4'hF;
`endif

    // ------------------------------------------------------------------
    // Fill FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_rem        <= '0;
            r_fill_value <= '0;
            r_fill_mask  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_rem        <= w_rem_nxt;
            r_fill_value <= w_fill_value_nxt;
            r_fill_mask  <= w_fill_mask_nxt;
            r_busy       <= (w_state_nxt == S_FILL);
            r_done       <= (w_state_nxt == S_DONE);
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_ptr_nxt        = r_ptr;
        w_rem_nxt        = r_rem;
        w_fill_value_nxt = r_fill_value;
        w_fill_mask_nxt  = r_fill_mask;
        w_fill_we        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (fill_start_i) begin
                    w_ptr_nxt        = fill_base_i;
                    w_rem_nxt        = fill_count_i;
                    w_fill_value_nxt = fill_value_i;
                    w_fill_mask_nxt  = w_fill_mask_in;
                    w_state_nxt      = (fill_count_i == '0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                // A CPU store in the same cycle owns the write port.
                if (!w_cpu_we) begin
                    w_fill_we = 1'b1;
                    w_ptr_nxt = r_ptr + c_WA'(1);
                    w_rem_nxt = r_rem - c_RW'(1);
                    if (r_rem == c_RW'(1)) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign fill_busy_o = r_busy;
    assign fill_done_o = r_done;

    // ------------------------------------------------------------------
    // Memory array: single write port, contents not reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (w_cpu_we) begin
            for (int b = 0; b < 4; b++) begin
                if (cpu_write_mask_i[b]) begin
                    r_mem[w_cpu_word][8*b +: 8] <= cpu_write_data_i[8*b +: 8];
                end
            end
        end else if (w_fill_we && !rst_i) begin
            for (int b = 0; b < 4; b++) begin
                if (r_fill_mask[b]) begin
                    r_mem[r_ptr][8*b +: 8] <= r_fill_value[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports (read-first through the first register stage)
    // ------------------------------------------------------------------
    assign w_pxl_word = pxl_addr_i[c_PA-1:c_LANE_BITS];

    generate
        if (c_LANE_BITS > 0) begin : g_lane
            assign w_pxl_lane = 2'(pxl_addr_i[c_LANE_BITS-1:0]);
        end else begin : g_no_lane
            assign w_pxl_lane = 2'd0;
        end
    endgenerate

    assign w_pxl_word_data = r_mem[w_pxl_word];
    assign w_pxl_sel       = w_pxl_word_data[w_pxl_lane*PXL_WIDTH +: PXL_WIDTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cpu_q1 <= '0;
            r_pxl_q1 <= '0;
        end else begin
            r_cpu_q1 <= r_mem[w_cpu_word];
            r_pxl_q1 <= w_pxl_sel;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [31:0]          r_cpu_q2;
            logic [PXL_WIDTH-1:0] r_pxl_q2;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_cpu_q2 <= '0;
                    r_pxl_q2 <= '0;
                end else begin
                    r_cpu_q2 <= r_cpu_q1;
                    r_pxl_q2 <= r_pxl_q1;
                end
            end
            assign cpu_read_data_o = r_cpu_q2;
            assign pxl_data_o      = r_pxl_q2;
        end else begin : g_lat1
            assign cpu_read_data_o = r_cpu_q1;
            assign pxl_data_o      = r_pxl_q1;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_video_ram_fill.sv
// ============================================================================
// Module   : tb_video_ram_fill
// Brief    : Scoreboard bench for video_ram_fill (8-bit/lat-1 and 16-bit/lat-2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_video_ram_fill;

    typedef struct {
        logic [31:0] exp;
        int          due;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cpu_addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wmask = '0;
    logic [11:0] pxl_addr = '0;
    logic [10:0] pxl2_addr = '0;
    logic        fill_start = 1'b0;
    logic [9:0]  fill_base = '0;
    logic [10:0] fill_count = '0;
    logic [31:0] fill_value = '0;
    logic [3:0]  fill_mask = 4'hF;

    logic [31:0] cpu_rd, cpu_rd2;
    logic [7:0]  pxl_d;
    logic [15:0] pxl2_d;
    logic        busy, done, busy2, done2;

    logic [31:0] m [1024];
    ent_t q_cpu[$], q_px[$], q_cpu2[$], q_px2[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    video_ram_fill #(.ADDR_WIDTH(12), .PXL_WIDTH(8), .READ_LATENCY(1)) dut (
        .clk_i(clk), .rst_i(rst), .cpu_addr_i(cpu_addr), .cpu_write_data_i(wdata),
        .cpu_write_mask_i(wmask), .cpu_read_data_o(cpu_rd), .pxl_addr_i(pxl_addr),
        .pxl_data_o(pxl_d), .fill_start_i(fill_start), .fill_base_i(fill_base),
        .fill_count_i(fill_count), .fill_value_i(fill_value),
`ifdef VIDEO_RAM_FILL_MASK_EN
        .fill_mask_i(fill_mask),
`endif
        .fill_busy_o(busy), .fill_done_o(done)
    );

    video_ram_fill #(.ADDR_WIDTH(12), .PXL_WIDTH(16), .READ_LATENCY(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .cpu_addr_i(cpu_addr), .cpu_write_data_i(wdata),
        .cpu_write_mask_i(wmask), .cpu_read_data_o(cpu_rd2), .pxl_addr_i(pxl2_addr),
        .pxl_data_o(pxl2_d), .fill_start_i(fill_start), .fill_base_i(fill_base),
        .fill_count_i(fill_count), .fill_value_i(fill_value),
`ifdef VIDEO_RAM_FILL_MASK_EN
        .fill_mask_i(fill_mask),
`endif
        .fill_busy_o(busy2), .fill_done_o(done2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%08h exp=%08h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] mask);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (mask[b]) r[8*b +: 8] = data[8*b +: 8];
        return r;
    endfunction

    // Scoreboard drain: every queued expectation is compared on its due cycle.
    always @(negedge clk) begin
        while (q_cpu.size() > 0 && q_cpu[0].due <= cyc) begin
            chk("cpu_rd_l1", cpu_rd, q_cpu[0].exp);
            void'(q_cpu.pop_front());
        end
        while (q_cpu2.size() > 0 && q_cpu2[0].due <= cyc) begin
            chk("cpu_rd_l2", cpu_rd2, q_cpu2[0].exp);
            void'(q_cpu2.pop_front());
        end
        while (q_px.size() > 0 && q_px[0].due <= cyc) begin
            chk("pxl8_l1", {24'h0, pxl_d}, q_px[0].exp);
            void'(q_px.pop_front());
        end
        while (q_px2.size() > 0 && q_px2[0].due <= cyc) begin
            chk("pxl16_l2", {16'h0, pxl2_d}, q_px2[0].exp);
            void'(q_px2.pop_front());
        end
    end

    task automatic cpu_wr(input int word, input logic [31:0] data, input logic [3:0] mask,
                          input bit check_old);
        @(negedge clk);
        cpu_addr   = 32'(word) << 2;
        wdata      = data;
        wmask      = mask;
        fill_start = 1'b0;
        if (check_old) begin
            q_cpu.push_back('{exp: m[word], due: cyc + 1});
            q_cpu2.push_back('{exp: m[word], due: cyc + 2});
        end
        m[word] = merge(m[word], data, mask);
    endtask

    task automatic rd(input int word, input int pk8, input int pk16);
        @(negedge clk);
        cpu_addr   = 32'(word) << 2;
        wmask      = 4'h0;
        fill_start = 1'b0;
        pxl_addr   = 12'(pk8);
        pxl2_addr  = 11'(pk16);
        q_cpu.push_back('{exp: m[word], due: cyc + 1});
        q_cpu2.push_back('{exp: m[word], due: cyc + 2});
        q_px.push_back('{exp: (m[pk8 >> 2] >> (8 * (pk8 & 3))) & 32'hFF, due: cyc + 1});
        q_px2.push_back('{exp: (m[pk16 >> 1] >> (16 * (pk16 & 1))) & 32'hFFFF, due: cyc + 2});
    endtask

    task automatic rdw(input int word);
        rd(word, word * 4 + (word & 3), word * 2 + (word & 1));
    endtask

    task automatic chk_flags(input string tag, input bit exp_busy, input bit exp_done);
        chk({tag, "_busy"}, {31'h0, busy}, {31'h0, exp_busy});
        chk({tag, "_done"}, {31'h0, done}, {31'h0, exp_done});
        chk({tag, "_busy2"}, {31'h0, busy2}, {31'h0, exp_busy});
        chk({tag, "_done2"}, {31'h0, done2}, {31'h0, exp_done});
    endtask

    // Start a fill; CPU stores to word 0x100 at cycles sa/sb, extra start at dup.
    task automatic run_fill(input string tag, input int base, input int count,
                            input logic [31:0] value, input int sa, input int sb, input int dup);
        int nst;
        int total;
        nst   = (sa != 0 ? 1 : 0) + (sb != 0 ? 1 : 0);
        total = count + nst;
        @(negedge clk);
        fill_start = 1'b1;
        fill_base  = 10'(base);
        fill_count = 11'(count);
        fill_value = value;
        wmask      = 4'h0;
        for (int i = 1; i <= total + 3; i++) begin
            @(negedge clk);
            chk_flags(tag, (i <= total), (i == total + 1));
            fill_start = (i == dup);
            if (i == sa || i == sb) begin
                cpu_addr = 32'h0000_0400;
                wdata    = 32'hC0DE_0000 | 32'(i);
                wmask    = 4'hF;
                m[256]   = wdata;
            end else begin
                wmask = 4'h0;
            end
        end
        for (int j = 0; j < count; j++) m[(base + j) % 1024] = merge(m[(base + j) % 1024], value, fill_mask);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) m[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_cpu_rd", cpu_rd, 32'h0);
        chk("rst_pxl", {24'h0, pxl_d}, 32'h0);
        chk("rst_cpu_rd2", cpu_rd2, 32'h0);
        chk("rst_pxl2", {16'h0, pxl2_d}, 32'h0);
        chk_flags("rst", 1'b0, 1'b0);
        rst = 1'b0;

        // Basic CPU write/read and pixel lane mapping.
        cpu_wr(4, 32'h4433_2211, 4'hF, 1'b0);
        for (int k = 0; k < 4; k++) rd(4, 16 + k, 8 + (k & 1));
        cpu_wr(0, 32'h4433_2211, 4'hF, 1'b0);
        rd(0, 0, 1);
        cpu_wr(5, 32'h1111_1111, 4'hF, 1'b0);
        cpu_wr(5, 32'hDEAD_BEEF, 4'h5, 1'b1);
        rd(5, 20, 10);
        rd(5, 23, 11);

        // Wrap-around fill, no CPU traffic.
        cpu_wr(1021, 32'h0101_0101, 4'hF, 1'b0);
        cpu_wr(2, 32'h1234_5678, 4'hF, 1'b0);
        run_fill("wrap", 1022, 4, 32'hA5A5_A5A5, 0, 0, 0);
        rdw(1021); rdw(1022); rdw(1023); rdw(0); rdw(1); rdw(2);

        // Fill with two CPU stalls and an ignored second start.
        cpu_wr(31, 32'h0F0F_F0F0, 4'hF, 1'b0);
        cpu_wr(40, 32'h7777_8888, 4'hF, 1'b0);
        run_fill("stall", 32, 8, 32'h3C3C_C3C3, 2, 5, 3);
        for (int w = 31; w <= 40; w++) rdw(w);
        rdw(256);

        // Zero-length fill.
        cpu_wr(48, 32'h0BAD_F00D, 4'hF, 1'b0);
        run_fill("zero", 48, 0, 32'hFFFF_FFFF, 0, 0, 0);
        rdw(48);

        // Reset during a fill after three writes.
        cpu_wr(515, 32'h3333_0303, 4'hF, 1'b0);
        cpu_wr(521, 32'h9999_0909, 4'hF, 1'b0);
        @(negedge clk);
        fill_start = 1'b1;
        fill_base  = 10'd512;
        fill_count = 11'd10;
        fill_value = 32'h5A5A_0F0F;
        wmask      = 4'h0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            fill_start = 1'b0;
            chk_flags("midrst", 1'b1, 1'b0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_cpu_rd", cpu_rd, 32'h0);
        chk("midrst_pxl", {24'h0, pxl_d}, 32'h0);
        chk("midrst_cpu_rd2", cpu_rd2, 32'h0);
        chk("midrst_pxl2", {16'h0, pxl2_d}, 32'h0);
        chk_flags("midrst_r", 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_flags("postrst", 1'b0, 1'b0);
        end
        for (int j = 0; j < 3; j++) m[512 + j] = 32'h5A5A_0F0F;
        for (int w = 512; w <= 516; w++) rdw(w);
        rdw(521);

`ifdef VIDEO_RAM_FILL_MASK_EN
        // Attribute-only clear, then an all-zero mask walk.
        cpu_wr(768, 32'h4433_2211, 4'hF, 1'b0);
        fill_mask = 4'h2;
        run_fill("mask2", 768, 1, 32'h0000_0000, 0, 0, 0);
        rdw(768);
        fill_mask = 4'h0;
        run_fill("mask0", 768, 2, 32'hFFFF_FFFF, 0, 0, 0);
        rdw(768); rdw(769);
        fill_mask = 4'hF;
`endif

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(q_cpu.size() + q_cpu2.size() + q_px.size() + q_px2.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/video_ram_fill.md
Name: video_ram_fill

Overview:
Single-clock, parametrised video RAM shared by the CPU bus and the pixel/text pipeline.
- CPU port: 32-bit word read/write with byte mask.
- Pixel port: read-only, PXL_WIDTH wide, configurable read latency.
- Built-in fill engine: clears or paints a word range (screen clear/scroll blanking) without CPU store loops; CPU stores have priority over it.

Parameters:
ADDR_WIDTH, 12, byte-address bits; DEPTH = 2**(ADDR_WIDTH-2) words.
PXL_WIDTH, 8, pixel read width in bits; legal 8, 16, 32.
READ_LATENCY, 1, cycles from address to data on both read ports; legal 1, 2.

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
cpu_addr_i  in  32  byte address; bits [ADDR_WIDTH-1:2] select the word, others ignored
cpu_write_data_i  in  32  write data, little-endian bytes
cpu_write_mask_i  in  4  byte write enables; 0 = read-only cycle
cpu_read_data_o  out  32  read data
pxl_addr_i  in  ADDR_WIDTH-log2(PXL_WIDTH/8)  pixel-unit address
pxl_data_o  out  PXL_WIDTH  pixel read data
fill_start_i  in  1  start-fill strobe, sampled in IDLE only
fill_base_i  in  ADDR_WIDTH-2  first word index
fill_count_i  in  ADDR_WIDTH-1  word count, 0..DEPTH
fill_value_i  in  32  fill word
fill_busy_o  out  1  high while in FILL
fill_done_o  out  1  one-cycle completion pulse

Behaviour:
- Clocking and reset: one clock (clk_i). Reset is synchronous, active-high (rst_i).
- Reset values: cpu_read_data_o=0, pxl_data_o=0, fill_busy_o=0, fill_done_o=0, state=IDLE.
- Memory contents are not reset; simulation initial contents are all zero.
- Reads:
  - CPU read is unconditional every cycle.
  - Latency 1: data valid the cycle after the address. Latency 2 adds one output register; both pipeline stages clear on reset.
  - Read-during-write at the same word returns old data (read-first), on both ports.
- Pixel mapping: unit k = pxl_addr_i selects word k/(32/PXL_WIDTH), lane k mod (32/PXL_WIDTH); lane 0 = bits [PXL_WIDTH-1:0].
- CPU write: every byte with mask=1 is written at the end of the cycle.
- Fill FSM: IDLE -> FILL -> DONE -> IDLE.
  - IDLE: on start with count!=0, latch ptr=base, rem=count, value -> FILL. On start with count==0, go to DONE with no writes.
  - FILL: a cycle with cpu_write_mask_i==0 writes value to mem[ptr], ptr=(ptr+1) mod DEPTH, rem-=1. A cycle with mask!=0 is a stall: the CPU write wins, nothing else changes. A write with rem==1 -> DONE.
  - DONE: fill_done_o=1 for exactly this cycle -> IDLE.
- fill_busy_o = (state==FILL), registered with the state.
- fill_start_i outside IDLE is ignored; nothing is queued.
- base+count > DEPTH wraps to word 0. count==DEPTH fills the whole RAM.
- Reset mid-fill: abort, no done pulse. Words already written keep the fill value.
- Minimum fill time: count+1 cycles from start to done pulse, plus one cycle per CPU-write stall.

Optional Feature:
Macro VIDEO_RAM_FILL_MASK_EN.
- Defined: adds input fill_mask_i[3:0], latched at start. Fill writes only the masked bytes (e.g. attribute-only clear). A mask of 0 still walks the range and pulses done, with no memory change.
- Undefined: port absent; fill writes all 4 bytes.

Test Plan:
- Defaults: CPU writes 0x44332211 mask 0xF at byte addr 0x010, then reads it -> cpu_read_data_o=0x44332211 next cycle. Pixel addrs 0x010..0x013 -> 0x11,0x22,0x33,0x44.
- Start fill base=0x3FE, count=4, value=0xA5A5A5A5 (DEPTH=1024), no CPU traffic:
  - words 0x3FE, 0x3FF, 0x000, 0x001 = fill value; word 0x002 unchanged.
  - busy high 4 cycles, done pulses on cycle 5.
- Fill count=8 with CPU writes to an unrelated word on 2 cycles during FILL -> CPU writes land, done delayed by 2 cycles, all 8 words filled.
- count=0 start -> no writes, busy stays 0, done pulses the cycle after start. Second start during FILL -> ignored, only one done pulse.
- rst_i asserted after 3 fill writes of 10 -> outputs 0 next cycle, no done pulse, first 3 words hold value, remainder unchanged.
- READ_LATENCY=2, PXL_WIDTH=16: pixel addr 1 over word 0x44332211 -> 0x4433 two cycles after the address. With VIDEO_RAM_FILL_MASK_EN, fill mask 0x2 over 0x44332211 with value 0 -> 0x44330011.
